// File: rtl/reg_scoreboard.sv
// Destination-register scoreboard: a saturating pending-write counter per register,
// with issue back-pressure, one-hot writeback enables and a sticky underflow flag.
module reg_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2,
  parameter int ZERO_HW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ready,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_rd,
  output logic [(2**ADDR_W)-1:0]    wb_load,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [(2**ADDR_W)-1:0]    busy_vec,
  output logic [ADDR_W+CNT_W-1:0]   inflight,
  output logic                      underflow
);

  localparam int NREGS = 2**ADDR_W;
  localparam int INF_W = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] MAXP = {CNT_W{1'b1}};
  localparam bit ZHW = (ZERO_HW != 0);

  logic [CNT_W-1:0] pend_reg  [NREGS];
  logic [CNT_W-1:0] pend_next [NREGS];
  logic [INF_W-1:0] inflight_reg, inflight_next;
  logic             underflow_reg, underflow_next;

  logic             wb_valid, issue_tracked, wb_tracked;
  logic             issue_acc, issue_eff, wb_dec, wb_under;
  logic [CNT_W-1:0] pend_issue, pend_wb;

  assign wb_valid      = wb_en && !flush;
  assign issue_tracked = !(ZHW && (issue_rd == '0));
  assign wb_tracked    = !(ZHW && (wb_rd == '0));
  assign pend_issue    = pend_reg[issue_rd];
  assign pend_wb       = pend_reg[wb_rd];

  // A full counter can still accept an issue when a same-cycle writeback frees a slot.
  assign issue_ready = (pend_issue != MAXP)
                    || (wb_valid && (wb_rd == issue_rd) && (pend_issue != '0))
                    || !issue_tracked;

  assign issue_acc = issue_valid && issue_ready && !flush;
  assign issue_eff = issue_acc && issue_tracked;
  assign wb_dec    = wb_valid && wb_tracked && (pend_wb != '0);
  assign wb_under  = wb_valid && wb_tracked && (pend_wb == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic inc, dec;
      assign inc = issue_eff && (issue_rd == IDX);
      assign dec = wb_dec && (wb_rd == IDX);
      assign pend_next[gi] = flush          ? '0 :
                             (inc && !dec)  ? pend_reg[gi] + 1'b1 :
                             (dec && !inc)  ? pend_reg[gi] - 1'b1 :
                                              pend_reg[gi];
      assign busy_vec[gi] = (pend_reg[gi] != '0);
    end
  endgenerate

  always_comb begin
    inflight_next = inflight_reg;
    if (flush) begin
      inflight_next = '0;
    end else if (issue_eff && !wb_dec) begin
      inflight_next = inflight_reg + 1'b1;
    end else if (wb_dec && !issue_eff) begin
      inflight_next = inflight_reg - 1'b1;
    end
  end

  // Underflow survives flush; only reset clears it.
  assign underflow_next = underflow_reg | wb_under;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        pend_reg[i] <= '0;
      end
      inflight_reg  <= '0;
      underflow_reg <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      inflight_reg  <= inflight_next;
      underflow_reg <= underflow_next;
    end
  end

  always_comb begin
    wb_load = '0;
    if (wb_en) begin
      wb_load[wb_rd] = 1'b1;
    end
    if (ZHW) begin
      wb_load[0] = 1'b0;
    end
  end

  assign rs1_busy  = busy_vec[rs1];
  assign rs2_busy  = busy_vec[rs2];
  assign inflight  = inflight_reg;
  assign underflow = underflow_reg;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5: destination-register address width; NREGS = 2**ADDR_W.
REQ-002 Parameter CNT_W, default 2: width of each per-register pending-write counter; MAXP = 2**CNT_W-1.
REQ-003 Parameter ZERO_HW, default 1: when 1, register 0 is hardwired and never tracked or written.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 issue_valid  input  1  an instruction with destination issue_rd requests issue.
REQ-007 issue_rd  input  ADDR_W  destination register of issuing instruction.
REQ-008 issue_ready  output  1  issue may be accepted this cycle (combinational).
REQ-009 wb_en  input  1  writeback to wb_rd occurs this cycle.
REQ-010 wb_rd  input  ADDR_W  writeback destination register.
REQ-011 wb_load  output  NREGS  one-hot register-file write enable (combinational).
REQ-012 flush  input  1  synchronous pipeline flush; clears all pending state.
REQ-013 rs1, rs2  input  ADDR_W each  source-register query addresses.
REQ-014 rs1_busy, rs2_busy  output  1 each  queried register has a pending write.
REQ-015 busy_vec  output  NREGS  bit r = 1 when pend[r] != 0.
REQ-016 inflight  output  ADDR_W+CNT_W  total pending writes over all registers.
REQ-017 underflow  output  1  sticky error flag.

Function
REQ-018 Module SHALL hold one CNT_W-bit counter pend[r] per register r; all outputs except wb_load and issue_ready SHALL derive from registered state only.
REQ-019 Issue accepted when issue_valid && issue_ready && !flush; wb valid when wb_en && !flush.
REQ-020 wb_load SHALL equal (1 << wb_rd) when wb_en=1, else all zeros; bit 0 forced 0 when ZERO_HW=1.
REQ-021 issue_ready SHALL be 1 when pend[issue_rd] < MAXP, or when valid wb targets issue_rd with pend[issue_rd] > 0 same cycle, or when issue_rd=0 and ZERO_HW=1; else 0.
REQ-022 Accepted issue to tracked rd SHALL increment pend[rd] by 1 next edge; accepted issue to rd=0 with ZERO_HW=1 SHALL change no state.
REQ-023 Valid wb to rd with pend[rd] > 0 SHALL decrement pend[rd] by 1; with pend[rd] = 0 (tracked rd) SHALL leave pend unchanged and set underflow.
REQ-024 Accepted issue and valid wb to same rd in same cycle SHALL leave pend[rd] unchanged (no underflow if pend>0 before).
REQ-025 Issue and wb to different registers in same cycle SHALL update both counters independently.
REQ-026 Counters SHALL never wrap: no increment past MAXP, no decrement below 0.
REQ-027 inflight SHALL equal sum of all pend[r] at every cycle, maintained incrementally (+1 accepted issue, -1 effective decrement, net 0 when both).
REQ-028 flush=1 SHALL clear all pend[] and inflight to 0 next edge, overriding same-cycle issue and wb; underflow is not cleared by flush.
REQ-029 rsN_busy SHALL equal busy_vec[rsN]; query of register 0 with ZERO_HW=1 SHALL return 0.
REQ-030 underflow SHALL remain 1 once set until rst.

Reset
REQ-031 rst=1 SHALL asynchronously clear all pend[], inflight=0, busy_vec=0, underflow=0, regardless of clk.
REQ-032 During rst, issue and wb inputs SHALL have no effect; first accepted update occurs on first rising edge after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all pending writes; no state survives.

Verification
REQ-034 Issue rd=5 three times (CNT_W=2) -> pend[5]=3, busy_vec[5]=1, inflight=3, then issue_ready=0 for rd=5 while issue_valid held.
REQ-035 pend[5]=3, same cycle issue rd=5 and wb rd=5 -> issue_ready=1, pend[5] stays 3, wb_load=0x00000020.
REQ-036 wb rd=7 with pend[7]=0 -> underflow=1, pend[7]=0, inflight unchanged; underflow persists across flush, clears only on rst.
REQ-037 Issue rd=0 (ZERO_HW=1) and wb rd=0 -> no state change, wb_load=0, issue_ready=1, rs1=0 gives rs1_busy=0.
REQ-038 pend[3]=2, pend[9]=1, flush with simultaneous issue rd=3 -> all pend=0, inflight=0 next cycle.
REQ-039 rst asserted between clock edges with inflight=4 -> inflight, busy_vec, underflow all 0 immediately, before next edge.
